feeder_layer_ctrl: RTL and testbench
====================================

Name: feeder_layer_ctrl

Overview:
Sequencer that owns one feeder instance and runs it across a list of convolution layers. For each layer it:
- drives the feeder geometry (stride, chans_per_mem, In_cols, k_dimension, o_dimension);
- resets the feeder;
- streams the input feature map from an upstream valid/ready source into the feeder write port, prefixed with the zero pre-roll;
- forwards the feeder's windowed read stream to a downstream sink;
- checks word counts, then advances to the next layer.

It sits between the input DMA/stream and the feeder and replaces bench-driven sequencing.

Parameters:
DATA_WIDTH, 16, feeder data word width
ADDR_WIDTH, 16, width of each geometry field
MAX_LAYERS, 8, depth of layer descriptor table
LIDX_W, 3, log2(MAX_LAYERS)
BATCH_SIZE, 1, batches per layer
RST_CYCLES, 4, cycles fd_rst held high per layer
READ_SKIP, 2, leading feeder output words discarded after ram_full
CNT_W, 32, width of word counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: run layers 0..num_layers-1
num_layers  in  LIDX_W+1  layer count, 1..MAX_LAYERS, sampled on start
cfg_we  in  1  descriptor write strobe, honoured only in IDLE
cfg_addr  in  LIDX_W  descriptor index
cfg_data  in  2+4*ADDR_WIDTH  {stride[1:0], chans, in_cols, k_dim, o_dim}, MSB first
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse on completion of the last layer
err  out  1  sticky count-mismatch flag, cleared on start
layer_idx  out  LIDX_W  current layer
src_data  in  DATA_WIDTH  input stream data
src_valid  in  1  input stream valid
src_ready  out  1  input stream ready
fd_rst  out  1  feeder reset, active-high
fd_start  out  1  feeder start
fd_valid_write  out  1  feeder write valid
fd_data_in  out  DATA_WIDTH  feeder write data
fd_ram_full  in  1  feeder RAM full
fd_data_out  in  DATA_WIDTH  feeder read data
fd_last_out  in  1  feeder final read word
fd_stride  out  2  feeder stride
fd_chans_per_mem  out  ADDR_WIDTH  feeder chans_per_mem
fd_in_cols  out  ADDR_WIDTH  feeder In_cols
fd_k_dimension  out  ADDR_WIDTH  feeder k_dimension
fd_o_dimension  out  ADDR_WIDTH  feeder o_dimension
snk_data  out  DATA_WIDTH  output stream data
snk_valid  out  1  output stream valid (no backpressure)

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; all outputs 0 except fd_rst=1.
  - Descriptor table contents undefined.
  - Reset mid-run aborts immediately; no done pulse.
- Per-layer derived values, computed in CFG at CNT_W with unsigned arithmetic and no overflow checking:
  - WR_TOT = in_cols*in_cols*chans*BATCH_SIZE
  - RD_TOT = k*k*chans*o*o*BATCH_SIZE
  - PAD = chans
- FSM states: IDLE, CFG, LOAD, DRAIN, NEXT, FIN.
- IDLE:
  - cfg_we writes the table.
  - start samples num_layers, sets layer_idx=0, clears err, then goes to CFG next cycle.
  - start in any other state is ignored.
- CFG:
  - Drive fd_* geometry from the table entry; geometry is held stable through NEXT.
  - fd_rst=1 for RST_CYCLES cycles, then fd_rst=0, fd_start=1, go to LOAD.
  - fd_start stays 1 until the next CFG or IDLE.
- LOAD:
  - First PAD cycles with !fd_ram_full: fd_valid_write=1, fd_data_in=0; src_ready=0.
  - Then src_ready = !fd_ram_full && (wr_cnt<WR_TOT).
  - Each src beat (src_valid&src_ready) is registered: next cycle fd_valid_write=1, fd_data_in=src_data; wr_cnt++.
  - Otherwise fd_valid_write=0.
  - fd_ram_full=1 → go to DRAIN. If wr_cnt!=WR_TOT at that point, set err.
  - A beat accepted in the cycle fd_ram_full rises still counts.
- DRAIN:
  - First READ_SKIP cycles discarded.
  - Every following cycle: snk_valid=1, snk_data=fd_data_out, rd_cnt++.
  - On fd_last_out=1: that cycle's word is not forwarded. If rd_cnt!=RD_TOT, set err. Go to NEXT.
  - fd_last_out during the skip window also goes to NEXT and sets err.
- NEXT:
  - One cycle; clears counters.
  - If layer_idx+1 == num_layers → FIN; else layer_idx++ → CFG.
- FIN: done=1 for one cycle, fd_rst=1, go to IDLE.
- Simultaneous events:
  - fd_ram_full and fd_last_out in the same LOAD cycle: the ram_full transition wins.
  - src_valid with ready=0 is held by upstream; no data is lost.
- num_layers=0 is treated as 1.

Test Plan:
- Single layer {stride=1, chans=4, in_cols=3, k=3, o=3}, BATCH_SIZE=1, feeder ram_full after 40 writes → exactly 4 zero writes then 36 src words in order; RD_TOT=324 snk_valid words; last_out on 325th post-skip cycle; done pulses once; err=0.
- Same layer, src_valid toggling 1/0 every cycle → fd_data_in sequence identical to the gap-free run; wr_cnt=36 at ram_full.
- Two layers (second: chans=2, in_cols=5, k=3, o=3) → fd_rst high for 4 cycles between layers; second layer takes 2 zeros + 50 writes; layer_idx 0→1; one done pulse.
- Feeder model asserts last_out after 300 words for layer 0 → err=1, sequencing still completes; err clears on next start.
- rst_n low during DRAIN → same cycle: busy=0, snk_valid=0, fd_rst=1; new start runs cleanly from layer 0.
- cfg_we and start pulsed while busy → table entry and run unaffected.

Source files
------------

// File: rtl/feeder_layer_ctrl.sv
// Layer sequencer for one feeder: programs geometry, resets the feeder, streams the
// zero pre-roll plus input map into it, forwards the windowed read stream and checks counts.
module feeder_layer_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_LAYERS = 8,
  parameter int LIDX_W     = 3,
  parameter int BATCH_SIZE = 1,
  parameter int RST_CYCLES = 4,
  parameter int READ_SKIP  = 2,
  parameter int CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LIDX_W:0]           num_layers,
  input  logic                      cfg_we,
  input  logic [LIDX_W-1:0]         cfg_addr,
  input  logic [2+4*ADDR_WIDTH-1:0] cfg_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [LIDX_W-1:0]         layer_idx,
  input  logic [DATA_WIDTH-1:0]     src_data,
  input  logic                      src_valid,
  output logic                      src_ready,
  output logic                      fd_rst,
  output logic                      fd_start,
  output logic                      fd_valid_write,
  output logic [DATA_WIDTH-1:0]     fd_data_in,
  input  logic                      fd_ram_full,
  input  logic [DATA_WIDTH-1:0]     fd_data_out,
  input  logic                      fd_last_out,
  output logic [1:0]                fd_stride,
  output logic [ADDR_WIDTH-1:0]     fd_chans_per_mem,
  output logic [ADDR_WIDTH-1:0]     fd_in_cols,
  output logic [ADDR_WIDTH-1:0]     fd_k_dimension,
  output logic [ADDR_WIDTH-1:0]     fd_o_dimension,
  output logic [DATA_WIDTH-1:0]     snk_data,
  output logic                      snk_valid
);

  localparam int CFG_W = 2 + 4*ADDR_WIDTH;
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  SKIP_N    = CNT_W'(READ_SKIP);
  localparam logic [CNT_W-1:0]  RST_N_CYC = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0]  BATCH_N   = CNT_W'(BATCH_SIZE);
  localparam logic [LIDX_W:0]   NL_ZERO   = {(LIDX_W+1){1'b0}};
  localparam logic [LIDX_W:0]   NL_ONE    = {{LIDX_W{1'b0}}, 1'b1};
  localparam logic [LIDX_W-1:0] LI_ZERO   = {LIDX_W{1'b0}};
  localparam logic [LIDX_W-1:0] LI_ONE    = {{(LIDX_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] D_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_LOAD, S_DRAIN, S_NEXT, S_FIN} state_t;

  state_t state_q, state_d;
  logic [CFG_W-1:0] tbl_q [MAX_LAYERS];
  logic [LIDX_W:0] num_layers_q, num_layers_d;
  logic [LIDX_W-1:0] layer_idx_q, layer_idx_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, src_ready_q, src_ready_d;
  logic fd_rst_q, fd_rst_d, fd_start_q, fd_start_d, fd_valid_write_q, fd_valid_write_d;
  logic snk_valid_q, snk_valid_d;
  logic [DATA_WIDTH-1:0] fd_data_in_q, fd_data_in_d, snk_data_q, snk_data_d;
  logic [1:0] fd_stride_q, fd_stride_d;
  logic [ADDR_WIDTH-1:0] fd_chans_q, fd_chans_d, fd_cols_q, fd_cols_d;
  logic [ADDR_WIDTH-1:0] fd_k_q, fd_k_d, fd_o_q, fd_o_d;
  logic [CNT_W-1:0] wr_tot_q, wr_tot_d, rd_tot_q, rd_tot_d, pad_q, pad_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, pad_cnt_q, pad_cnt_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d, rst_cnt_q, rst_cnt_d;

  logic [CFG_W-1:0] ent_s;
  logic [ADDR_WIDTH-1:0] ent_chans_s, ent_cols_s, ent_k_s, ent_o_s;
  logic [CNT_W-1:0] c_w_s, ic_w_s, k_w_s, o_w_s, wr_next_s;
  logic beat_s;

  assign ent_s       = tbl_q[layer_idx_q];
  assign ent_chans_s = ent_s[4*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign ent_cols_s  = ent_s[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign ent_k_s     = ent_s[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign ent_o_s     = ent_s[ADDR_WIDTH-1:0];
  assign c_w_s       = CNT_W'(ent_chans_s);
  assign ic_w_s      = CNT_W'(ent_cols_s);
  assign k_w_s       = CNT_W'(ent_k_s);
  assign o_w_s       = CNT_W'(ent_o_s);
  assign beat_s      = src_valid & src_ready_q;
  assign wr_next_s   = beat_s ? (wr_cnt_q + CNT_ONE) : wr_cnt_q;

  // Descriptor table; writable only while idle, so geometry cannot move under a run.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == S_IDLE)) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  // Next-state and next-output logic for the layer sequencer.
  always_comb begin
    state_d          = state_q;
    num_layers_d     = num_layers_q;
    layer_idx_d      = layer_idx_q;
    done_d           = 1'b0;
    err_d            = err_q;
    src_ready_d      = 1'b0;
    fd_rst_d         = fd_rst_q;
    fd_start_d       = fd_start_q;
    fd_valid_write_d = 1'b0;
    fd_data_in_d     = fd_data_in_q;
    snk_valid_d      = 1'b0;
    snk_data_d       = snk_data_q;
    fd_stride_d      = fd_stride_q;
    fd_chans_d       = fd_chans_q;
    fd_cols_d        = fd_cols_q;
    fd_k_d           = fd_k_q;
    fd_o_d           = fd_o_q;
    wr_tot_d         = wr_tot_q;
    rd_tot_d         = rd_tot_q;
    pad_d            = pad_q;
    wr_cnt_d         = wr_cnt_q;
    rd_cnt_d         = rd_cnt_q;
    pad_cnt_d        = pad_cnt_q;
    skip_cnt_d       = skip_cnt_q;
    rst_cnt_d        = rst_cnt_q;
    case (state_q)
      S_IDLE: begin
        fd_rst_d   = 1'b1;
        fd_start_d = 1'b0;
        if (start) begin
          state_d      = S_CFG;
          num_layers_d = (num_layers == NL_ZERO) ? NL_ONE : num_layers;
          layer_idx_d  = LI_ZERO;
          err_d        = 1'b0;
          rst_cnt_d    = CNT_ZERO;
          wr_cnt_d     = CNT_ZERO;
          rd_cnt_d     = CNT_ZERO;
          pad_cnt_d    = CNT_ZERO;
          skip_cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CFG: begin
        fd_stride_d = ent_s[CFG_W-1 -: 2];
        fd_chans_d  = ent_chans_s;
        fd_cols_d   = ent_cols_s;
        fd_k_d      = ent_k_s;
        fd_o_d      = ent_o_s;
        wr_tot_d    = ic_w_s * ic_w_s * c_w_s * BATCH_N;
        rd_tot_d    = k_w_s * k_w_s * c_w_s * o_w_s * o_w_s * BATCH_N;
        pad_d       = c_w_s;
        if ((rst_cnt_q + CNT_ONE) >= RST_N_CYC) begin
          fd_rst_d   = 1'b0;
          fd_start_d = 1'b1;
          state_d    = S_LOAD;
        end else begin
          fd_rst_d   = 1'b1;
          fd_start_d = 1'b0;
          rst_cnt_d  = rst_cnt_q + CNT_ONE;
        end
      end
      S_LOAD: begin
        // src_ready is registered, so a beat can still land in the cycle ram_full rises.
        if (fd_ram_full) begin
          fd_valid_write_d = beat_s;
          fd_data_in_d     = src_data;
          wr_cnt_d         = wr_next_s;
          state_d          = S_DRAIN;
          err_d            = err_q | (wr_next_s != wr_tot_q);
        end else if (pad_cnt_q < pad_q) begin
          fd_valid_write_d = 1'b1;
          fd_data_in_d     = D_ZERO;
          pad_cnt_d        = pad_cnt_q + CNT_ONE;
          src_ready_d      = ((pad_cnt_q + CNT_ONE) >= pad_q) && (wr_cnt_q < wr_tot_q);
        end else begin
          fd_valid_write_d = beat_s;
          fd_data_in_d     = beat_s ? src_data : fd_data_in_q;
          wr_cnt_d         = wr_next_s;
          src_ready_d      = (wr_next_s < wr_tot_q);
        end
      end
      S_DRAIN: begin
        if (fd_last_out) begin
          state_d = S_NEXT;
          err_d   = err_q | (skip_cnt_q < SKIP_N) | (rd_cnt_q != rd_tot_q);
        end else if (skip_cnt_q < SKIP_N) begin
          skip_cnt_d = skip_cnt_q + CNT_ONE;
        end else begin
          snk_valid_d = 1'b1;
          snk_data_d  = fd_data_out;
          rd_cnt_d    = rd_cnt_q + CNT_ONE;
        end
      end
      S_NEXT: begin
        wr_cnt_d   = CNT_ZERO;
        rd_cnt_d   = CNT_ZERO;
        pad_cnt_d  = CNT_ZERO;
        skip_cnt_d = CNT_ZERO;
        rst_cnt_d  = CNT_ZERO;
        if (({1'b0, layer_idx_q} + NL_ONE) == num_layers_q) begin
          state_d = S_FIN;
        end else begin
          layer_idx_d = layer_idx_q + LI_ONE;
          state_d     = S_CFG;
          fd_rst_d    = 1'b1;
          fd_start_d  = 1'b0;
        end
      end
      S_FIN: begin
        done_d     = 1'b1;
        fd_rst_d   = 1'b1;
        fd_start_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        fd_rst_d   = 1'b1;
        fd_start_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset parks the feeder in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      num_layers_q     <= NL_ONE;
      layer_idx_q      <= LI_ZERO;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      src_ready_q      <= 1'b0;
      fd_rst_q         <= 1'b1;
      fd_start_q       <= 1'b0;
      fd_valid_write_q <= 1'b0;
      fd_data_in_q     <= D_ZERO;
      snk_valid_q      <= 1'b0;
      snk_data_q       <= D_ZERO;
      fd_stride_q      <= 2'b00;
      fd_chans_q       <= {ADDR_WIDTH{1'b0}};
      fd_cols_q        <= {ADDR_WIDTH{1'b0}};
      fd_k_q           <= {ADDR_WIDTH{1'b0}};
      fd_o_q           <= {ADDR_WIDTH{1'b0}};
      wr_tot_q         <= CNT_ZERO;
      rd_tot_q         <= CNT_ZERO;
      pad_q            <= CNT_ZERO;
      wr_cnt_q         <= CNT_ZERO;
      rd_cnt_q         <= CNT_ZERO;
      pad_cnt_q        <= CNT_ZERO;
      skip_cnt_q       <= CNT_ZERO;
      rst_cnt_q        <= CNT_ZERO;
    end else begin
      state_q          <= state_d;
      num_layers_q     <= num_layers_d;
      layer_idx_q      <= layer_idx_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_q            <= err_d;
      src_ready_q      <= src_ready_d;
      fd_rst_q         <= fd_rst_d;
      fd_start_q       <= fd_start_d;
      fd_valid_write_q <= fd_valid_write_d;
      fd_data_in_q     <= fd_data_in_d;
      snk_valid_q      <= snk_valid_d;
      snk_data_q       <= snk_data_d;
      fd_stride_q      <= fd_stride_d;
      fd_chans_q       <= fd_chans_d;
      fd_cols_q        <= fd_cols_d;
      fd_k_q           <= fd_k_d;
      fd_o_q           <= fd_o_d;
      wr_tot_q         <= wr_tot_d;
      rd_tot_q         <= rd_tot_d;
      pad_q            <= pad_d;
      wr_cnt_q         <= wr_cnt_d;
      rd_cnt_q         <= rd_cnt_d;
      pad_cnt_q        <= pad_cnt_d;
      skip_cnt_q       <= skip_cnt_d;
      rst_cnt_q        <= rst_cnt_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign layer_idx        = layer_idx_q;
  assign src_ready        = src_ready_q;
  assign fd_rst           = fd_rst_q;
  assign fd_start         = fd_start_q;
  assign fd_valid_write   = fd_valid_write_q;
  assign fd_data_in       = fd_data_in_q;
  assign snk_valid        = snk_valid_q;
  assign snk_data         = snk_data_q;
  assign fd_stride        = fd_stride_q;
  assign fd_chans_per_mem = fd_chans_q;
  assign fd_in_cols       = fd_cols_q;
  assign fd_k_dimension   = fd_k_q;
  assign fd_o_dimension   = fd_o_q;

endmodule

// File: tb/tb_feeder_layer_ctrl.sv
// Scoreboard bench for feeder_layer_ctrl: a behavioural feeder model plus random source data;
// expected write and sink streams are queued at issue time and popped by independent monitors.
module tb_feeder_layer_ctrl;
  localparam int DW = 16, AW = 16, ML = 8, LW = 3, RSK = 2, RSTC = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, cfg_we = 1'b0, src_valid = 1'b0;
  logic [LW:0] num_layers = '0;
  logic [LW-1:0] cfg_addr = '0;
  logic [2+4*AW-1:0] cfg_data = '0;
  logic [DW-1:0] src_data = '0, fd_data_out = '0;
  logic fd_ram_full = 1'b0, fd_last_out = 1'b0;
  logic busy, done, err, src_ready, fd_rst, fd_start, fd_valid_write, snk_valid;
  logic [LW-1:0] layer_idx;
  logic [DW-1:0] fd_data_in, snk_data;
  logic [1:0] fd_stride;
  logic [AW-1:0] fd_chans_per_mem, fd_in_cols, fd_k_dimension, fd_o_dimension;

  feeder_layer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_layers(num_layers),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .done(done), .err(err), .layer_idx(layer_idx),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .fd_rst(fd_rst), .fd_start(fd_start), .fd_valid_write(fd_valid_write),
    .fd_data_in(fd_data_in), .fd_ram_full(fd_ram_full), .fd_data_out(fd_data_out),
    .fd_last_out(fd_last_out), .fd_stride(fd_stride), .fd_chans_per_mem(fd_chans_per_mem),
    .fd_in_cols(fd_in_cols), .fd_k_dimension(fd_k_dimension), .fd_o_dimension(fd_o_dimension),
    .snk_data(snk_data), .snk_valid(snk_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int lay_s[ML], lay_c[ML], lay_ic[ML], lay_k[ML], lay_o[ML], lay_nrd[ML];
  int run_nl = 0, fl_layer = -1, fl_wr = 0, fl_post = 0, rst_len = 0;
  int snk_seen = 0, done_cnt = 0;
  bit fl_full = 1'b0, fl_fin = 1'b0, prev_rst = 1'b1, toggle_mode = 1'b0, tog = 1'b0;
  logic [DW-1:0] exp_wr[$], exp_snk[$], src_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic int cap_of(input int l);
    return lay_c[l] + lay_ic[l] * lay_ic[l] * lay_c[l];
  endfunction

  // Feeder model: fills after pad+map writes, then emits random words and a final last_out.
  always @(negedge clk) begin
    if (!rst_n || fd_rst) begin
      fd_ram_full = 1'b0; fd_last_out = 1'b0; fd_data_out = '0;
      fl_full = 1'b0; fl_fin = 1'b0; fl_wr = 0; fl_post = 0; prev_rst = 1'b1;
      rst_len = rst_n ? rst_len + 1 : 0;
    end else begin
      if (prev_rst) begin
        fl_layer++;
        if (fl_layer < run_nl) begin
          check("geom_stride", 64'(fd_stride), 64'(lay_s[fl_layer]));
          check("geom_dims", {fd_chans_per_mem, fd_in_cols, fd_k_dimension, fd_o_dimension},
                {lay_c[fl_layer][15:0], lay_ic[fl_layer][15:0], lay_k[fl_layer][15:0], lay_o[fl_layer][15:0]});
          check("layer_idx", 64'(layer_idx), 64'(fl_layer));
          check("fd_start", 64'(fd_start), 64'd1);
          if (fl_layer > 0) check("rst_len", 64'(rst_len), 64'(RSTC));
        end else begin
          check("layer_count", 64'(fl_layer), 64'(run_nl - 1));
        end
        rst_len = 0;
        prev_rst = 1'b0;
      end
      if (!fl_full) begin
        if (fd_valid_write) fl_wr++;
        if (fl_layer < run_nl && fl_wr == cap_of(fl_layer)) begin
          fl_full = 1'b1; fd_ram_full = 1'b1; fl_post = 0;
        end
      end else if (!fl_fin) begin
        fl_post++;
        fd_data_out = 16'($urandom);
        fd_last_out = (fl_post == RSK + 1 + lay_nrd[fl_layer]);
        if (fd_last_out) fl_fin = 1'b1;
        else if (fl_post >= RSK + 1) exp_snk.push_back(fd_data_out);
      end else begin
        fd_last_out = 1'b0; fd_data_out = '0;
      end
    end
  end

  // Upstream source: offers queued words, optionally on alternate cycles, holding until accepted.
  always @(negedge clk) begin
    if (!rst_n || src_q.size() == 0) begin
      src_valid = 1'b0;
    end else begin
      tog = ~tog;
      src_valid = toggle_mode ? tog : 1'b1;
      src_data = src_q[0];
      if (src_valid && src_ready) void'(src_q.pop_front());
    end
  end

  // Write-port monitor.
  always @(negedge clk) begin
    if (rst_n && fd_valid_write) begin
      if (exp_wr.size() == 0) check("wr_extra", 64'(fd_data_in), 64'hDEAD_0000_0000);
      else check("wr_data", 64'(fd_data_in), 64'(exp_wr.pop_front()));
    end
  end

  // Sink monitor and done counter.
  always @(negedge clk) begin
    if (rst_n && snk_valid) begin
      snk_seen++;
      if (exp_snk.size() == 0) check("snk_extra", 64'(snk_data), 64'hDEAD_0000_0000);
      else check("snk_data", 64'(snk_data), 64'(exp_snk.pop_front()));
    end
    if (rst_n && done) done_cnt++;
  end

  task automatic write_cfg(input int nl);
    for (int l = 0; l < nl; l++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = LW'(l);
      cfg_data = {lay_s[l][1:0], lay_c[l][15:0], lay_ic[l][15:0], lay_k[l][15:0], lay_o[l][15:0]};
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic prep(input int nl);
    logic [DW-1:0] w;
    exp_wr.delete(); exp_snk.delete(); src_q.delete();
    run_nl = nl; fl_layer = -1; done_cnt = 0; snk_seen = 0;
    for (int l = 0; l < nl; l++) begin
      for (int i = 0; i < lay_c[l]; i++) exp_wr.push_back('0);
      for (int i = 0; i < lay_ic[l] * lay_ic[l] * lay_c[l]; i++) begin
        w = 16'($urandom);
        exp_wr.push_back(w);
        src_q.push_back(w);
      end
    end
  endtask

  task automatic kick(input int nl);
    @(negedge clk);
    start = 1'b1; num_layers = (LW+1)'(nl);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("err_cleared", 64'(err), 64'd0);
  endtask

  task automatic run(input int nl, input bit exp_err, input bit poke);
    bit seen = 1'b0;
    prep(nl);
    kick(nl);
    if (poke) begin
      repeat (20) @(negedge clk);
      cfg_we = 1'b1; cfg_addr = '0; cfg_data = {2'b11, 16'd9, 16'd9, 16'd9, 16'd9};
      start = 1'b1; num_layers = 4'd3;
      @(negedge clk);
      cfg_we = 1'b0; start = 1'b0;
    end
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("err_at_done", 64'(err), 64'(exp_err));
    check("layer_idx_final", 64'(layer_idx), 64'(nl - 1));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("fd_rst_idle", 64'(fd_rst), 64'd1);
    check("wr_left", 64'(exp_wr.size()), 64'd0);
    check("snk_left", 64'(exp_snk.size()), 64'd0);
    check("src_left", 64'(src_q.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    bit hit;
    lay_s[0] = 1; lay_c[0] = 4; lay_ic[0] = 3; lay_k[0] = 3; lay_o[0] = 3; lay_nrd[0] = 324;
    lay_s[1] = 2; lay_c[1] = 2; lay_ic[1] = 5; lay_k[1] = 3; lay_o[1] = 3; lay_nrd[1] = 162;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_fd_rst", 64'(fd_rst), 64'd1);
    check("rst_fd_start", 64'(fd_start), 64'd0);
    check("rst_src_ready", 64'(src_ready), 64'd0);
    check("rst_fd_vw", 64'(fd_valid_write), 64'd0);
    check("rst_snk_valid", 64'(snk_valid), 64'd0);
    check("rst_layer_idx", 64'(layer_idx), 64'd0);
    rst_n = 1'b1;
    write_cfg(2);

    run(1, 1'b0, 1'b0);
    toggle_mode = 1'b1;
    run(1, 1'b0, 1'b1);
    toggle_mode = 1'b0;
    run(2, 1'b0, 1'b0);
    lay_nrd[0] = 300;
    run(1, 1'b1, 1'b0);
    lay_nrd[0] = 324;

    prep(1);
    kick(1);
    hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk);
      if (snk_seen >= 10) hit = 1'b1;
    end
    check("drain_reached", 64'(hit), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_snk_valid", 64'(snk_valid), 64'd0);
    check("abort_fd_rst", 64'(fd_rst), 64'd1);
    exp_wr.delete(); exp_snk.delete(); src_q.delete();
    repeat (2) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    write_cfg(2);
    run(1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
